dmem_controller: RTL and testbench



---
 rtl/dmem_controller_pkg.sv | 34 +++
 rtl/dmem_load_align.sv | 31 +++
 rtl/dmem_controller.sv | 147 ++++++++++++++
 tb/tb_dmem_controller.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_controller_pkg.sv
// rtl/dmem_controller_pkg.sv - shared types and helpers for the data-memory controller
package dmem_controller_pkg;

    localparam int RAM_BE_WIDTH = 4;

    // Memory operations, encoded as {isStore, func3} so load and store share func3 codes
    typedef enum logic [3:0] {
        LB  = 4'b0000,
        LH  = 4'b0001,
        LW  = 4'b0010,
        LBU = 4'b0100,
        LHU = 4'b0101,
        SB  = 4'b1000,
        SH  = 4'b1001,
        SW  = 4'b1010
    } mem_func3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // True when func3 names a real load (isStore=0) or store (isStore=1)
    function automatic logic isLegalOp(input logic isStore, input logic [2:0] func3);
        logic legal;
        case ({isStore, func3})
            LB, LH, LW, LBU, LHU, SB, SH, SW: legal = 1'b1;
            default:                          legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - selects and extends the loaded byte/half/word
module dmem_load_align
    import dmem_controller_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] ramRdata,
    input  logic [1:0]            offset,
    input  logic [2:0]            func3,
    output logic [DATA_WIDTH-1:0] loadData
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Pick the addressed lane, then sign- or zero-extend according to the load type
    always_comb begin
        byteSel  = ramRdata[{offset, 3'b000} +: 8];
        halfSel  = offset[1] ? ramRdata[31:16] : ramRdata[15:0];
        loadData = '0;
        case ({1'b0, func3})
            LB:      loadData = {{(DATA_WIDTH-8){byteSel[7]}}, byteSel};
            LBU:     loadData = {{(DATA_WIDTH-8){1'b0}}, byteSel};
            LH:      loadData = {{(DATA_WIDTH-16){halfSel[15]}}, halfSel};
            LHU:     loadData = {{(DATA_WIDTH-16){1'b0}}, halfSel};
            LW:      loadData = ramRdata;
            default: loadData = '0;
        endcase
    end

endmodule

// File: rtl/dmem_controller.sv
// rtl/dmem_controller.sv - sequences Mem-stage loads/stores onto a single-port word RAM
module dmem_controller
    import dmem_controller_pkg::*;
#(
    parameter int DM_MEM_DEPTH = 4096,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2,
    localparam int ADDR_W      = $clog2(DM_MEM_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic                    memRead,
    input  logic                    memWrite,
    input  logic [2:0]              func3,
    input  logic [DATA_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    ready,
    output logic                    errMisalign,
    output logic                    ramEn,
    output logic                    ramWe,
    output logic [RAM_BE_WIDTH-1:0] ramBe,
    output logic [ADDR_W-1:0]       ramAddr,
    output logic [DATA_WIDTH-1:0]   ramWdata,
    input  logic [DATA_WIDTH-1:0]   ramRdata
);

    dmem_state_t            state;
    dmem_state_t            nextState;
    logic [2:0]             waitCnt;
    logic [2:0]             func3Q;
    logic [1:0]             offsetQ;
    logic [DATA_WIDTH-1:0]  loadData;
    logic                   anyReq;
    logic                   aligned;
    logic                   inRange;
    logic                   legal;
    logic                   issue;
    logic                   reqErr;
    logic [RAM_BE_WIDTH-1:0] storeBe;
    logic [DATA_WIDTH-1:0]  storeData;

    dmem_load_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) uLoadAlign (
        .ramRdata(ramRdata),
        .offset  (offsetQ),
        .func3   (func3Q),
        .loadData(loadData)
    );

    // Classify the incoming request: alignment, range and opcode legality
    always_comb begin
        anyReq = memRead | memWrite;
        case (func3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        inRange = (addr >> 2) < DATA_WIDTH'(DM_MEM_DEPTH);
        legal   = (memRead ^ memWrite) && isLegalOp(memWrite, func3) && aligned && inRange;
        issue   = (state == IDLE) && legal;
        reqErr  = (state == IDLE) && anyReq && !legal;
    end

    // Store byte enables and lane-replicated write data
    always_comb begin
        storeBe   = '0;
        storeData = '0;
        case (func3[1:0])
            2'b00: begin
                storeBe   = 4'b0001 << addr[1:0];
                storeData = {4{wdata[7:0]}};
            end
            2'b01: begin
                storeBe   = addr[1] ? 4'b1100 : 4'b0011;
                storeData = {2{wdata[15:0]}};
            end
            2'b10: begin
                storeBe   = 4'b1111;
                storeData = wdata;
            end
            default: ;
        endcase
    end

    // Next-state and RAM strobes; RAM outputs are only non-zero in the issue cycle
    always_comb begin
        nextState = state;
        ramEn     = 1'b0;
        ramWe     = 1'b0;
        ramBe     = '0;
        ramAddr   = '0;
        ramWdata  = '0;
        case (state)
            IDLE: begin
                if (issue) begin
                    ramEn     = 1'b1;
                    ramWe     = memWrite;
                    ramAddr   = addr[2 +: ADDR_W];
                    ramBe     = memWrite ? storeBe : '1;
                    ramWdata  = memWrite ? storeData : '0;
                    nextState = memWrite ? RESP : WAIT;
                end else if (anyReq) begin
                    nextState = RESP;
                end
            end
            WAIT: begin
                if (waitCnt == 3'd0) begin
                    nextState = RESP;
                end
            end
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
        ready = (state == RESP) || ((state == IDLE) && !anyReq);
    end

    // State, latency counter, latched load info, result and error pulse
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state       <= IDLE;
            waitCnt     <= 3'd0;
            func3Q      <= 3'd0;
            offsetQ     <= 2'd0;
            rdata       <= '0;
            errMisalign <= 1'b0;
        end else begin
            state       <= nextState;
            errMisalign <= reqErr;
            if (issue) begin
                func3Q  <= func3;
                offsetQ <= addr[1:0];
                waitCnt <= 3'(READ_LATENCY - 1);
            end else if ((state == WAIT) && (waitCnt != 3'd0)) begin
                waitCnt <= waitCnt - 3'd1;
            end
            if (reqErr) begin
                rdata <= '0;
            end else if ((state == WAIT) && (waitCnt == 3'd0)) begin
                rdata <= loadData;
            end
        end
    end

endmodule

// File: tb/tb_dmem_controller.sv
// tb/tb_dmem_controller.sv - self-checking bench for dmem_controller
module tb_dmem_controller;

    localparam int DEPTH = 4096;
    localparam int LAT   = 2;
    localparam int AW    = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [2:0]  func3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        ready;
    logic        errMisalign;
    logic        ramEn;
    logic        ramWe;
    logic [3:0]  ramBe;
    logic [AW-1:0] ramAddr;
    logic [31:0] ramWdata;
    logic [31:0] ramRdata;

    int testCount = 0;
    int failCount = 0;
    int enCount = 0;
    int rdyCount = 0;
    bit countOn = 1'b0;

    always #5 clk = ~clk;

    dmem_controller #(
        .DM_MEM_DEPTH(DEPTH),
        .DATA_WIDTH  (32),
        .READ_LATENCY(LAT)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .func3      (func3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .errMisalign(errMisalign),
        .ramEn      (ramEn),
        .ramWe      (ramWe),
        .ramBe      (ramBe),
        .ramAddr    (ramAddr),
        .ramWdata   (ramWdata),
        .ramRdata   (ramRdata)
    );

    // RAM macro model with a LAT-deep read pipeline
    logic [31:0] ramArr [DEPTH];
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        if (ramEn && ramWe) begin
            for (int b = 0; b < 4; b++)
                if (ramBe[b]) ramArr[ramAddr][8*b +: 8] <= ramWdata[8*b +: 8];
        end
        pipe[0] <= ramArr[ramAddr];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ramRdata = pipe[LAT-1];

    // Per-cycle pulse counters
    always @(negedge clk) begin
        if (countOn) begin
            enCount  += int'(ramEn);
            rdyCount += int'(ready);
        end
    end

    // Byte-addressed reference memory
    logic [7:0] refMem [int unsigned];

    function automatic logic [7:0] refByte(input logic [31:0] a);
        return refMem.exists(a) ? refMem[a] : 8'h00;
    endfunction

    function automatic int accSize(input bit rd, input bit wr, input logic [2:0] f3);
        if (rd && wr) return 0;
        if (rd) begin
            case (f3)
                3'd0, 3'd4: return 1;
                3'd1, 3'd5: return 2;
                3'd2:       return 4;
                default:    return 0;
            endcase
        end
        if (wr) begin
            case (f3)
                3'd0:    return 1;
                3'd1:    return 2;
                3'd2:    return 4;
                default: return 0;
            endcase
        end
        return 0;
    endfunction

    function automatic logic [31:0] expLoad(input logic [2:0] f3, input logic [31:0] a, input int size);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < size; i++) v |= 32'(refByte(a + 32'(i))) << (8*i);
        if (!f3[2] && size < 4 && v[8*size-1]) v |= ~((32'h1 << (8*size)) - 32'h1);
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, ".idleReady"}, 32'(ready), 32'd1);
        check({tag, ".idleEn"}, 32'(ramEn), 32'd0);
        check({tag, ".idleErr"}, 32'(errMisalign), 32'd0);
    endtask

    task automatic access(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input bit scramble,
                          output logic [31:0] got);
        int size;
        int lat;
        int expLat;
        bit err;
        logic [31:0] expData;
        logic [3:0] expBe;
        logic [31:0] expWd;
        size   = accSize(rd, wr, f3);
        err    = (size == 0) || ((a >> 2) >= 32'(DEPTH)) || ((a % 32'(size)) != 0);
        expLat = (!err && rd) ? LAT + 1 : 1;
        expData = err ? 32'd0 : expLoad(f3, a, size);
        expBe  = err ? 4'd0 : 4'(((1 << size) - 1) << a[1:0]);
        expWd  = (size == 1) ? {4{wd[7:0]}} : (size == 2) ? {2{wd[15:0]}} : wd;

        @(posedge clk); #1;
        memRead = rd; memWrite = wr; func3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        check({tag, ".ramEn"}, 32'(ramEn), 32'(!err));
        check({tag, ".reqReady"}, 32'(ready), 32'd0);
        if (!err) begin
            check({tag, ".ramWe"}, 32'(ramWe), 32'(wr));
            check({tag, ".ramAddr"}, 32'(ramAddr), 32'(a[2 +: AW]));
            if (wr) begin
                check({tag, ".ramBe"}, 32'(ramBe), 32'(expBe));
                check({tag, ".ramWdata"}, ramWdata, expWd);
            end
        end
        lat = 0;
        do begin
            @(posedge clk); #1;
            if (scramble) begin
                memRead = 1'b0; memWrite = 1'b0;
                func3 = 3'($urandom); addr = $urandom;
            end
            @(negedge clk);
            lat++;
        end while (ready !== 1'b1 && lat < 20);
        check({tag, ".latency"}, 32'(lat), 32'(expLat));
        check({tag, ".err"}, 32'(errMisalign), 32'(err));
        if (err) check({tag, ".errRdata"}, rdata, 32'd0);
        else if (rd) check({tag, ".rdata"}, rdata, expData);
        got = rdata;
        memRead = 1'b0; memWrite = 1'b0;
        if (!err && wr)
            for (int i = 0; i < size; i++) refMem[a + 32'(i)] = wd[8*i +: 8];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        int r;
        bit rd;
        bit wr;
        logic [2:0] f3;
        logic [31:0] a;

        for (int i = 0; i < DEPTH; i++) ramArr[i] = 32'd0;
        for (int i = 0; i < LAT; i++) pipe[i] = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.ready", 32'(ready), 32'd1);
        check("rst.ramEn", 32'(ramEn), 32'd0);
        check("rst.rdata", rdata, 32'd0);
        check("rst.err", 32'(errMisalign), 32'd0);
        rstN = 1'b1;
        checkIdle("rst");

        // Directed stores and loads
        access("sw10", 1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, got);
        checkIdle("sw10");
        access("sw10b", 1'b0, 1'b1, 3'd2, 32'h10, 32'h8899AABB, 1'b0, got);
        access("lb13", 1'b1, 1'b0, 3'd0, 32'h13, 32'h0, 1'b0, got);
        check("lb13.const", got, 32'hFFFFFF88);
        access("lbu13", 1'b1, 1'b0, 3'd4, 32'h13, 32'h0, 1'b0, got);
        check("lbu13.const", got, 32'h00000088);
        access("lhu10", 1'b1, 1'b0, 3'd5, 32'h10, 32'h0, 1'b0, got);
        check("lhu10.const", got, 32'h0000AABB);
        access("sh12", 1'b0, 1'b1, 3'd1, 32'h12, 32'h1234, 1'b0, got);
        access("lw10", 1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, got);
        check("lw10.const", got, 32'h1234AABB);
        checkIdle("lw10");

        // Reset during WAIT
        @(posedge clk); #1;
        memRead = 1'b1; func3 = 3'd2; addr = 32'h10;
        @(negedge clk);
        @(posedge clk); #1;
        memRead = 1'b0;
        enCount = 0; rdyCount = 0; countOn = 1'b1;
        #2 rstN = 1'b0;
        #1;
        check("rstWait.ramEn", 32'(ramEn), 32'd0);
        check("rstWait.ready", 32'(ready), 32'd1);
        check("rstWait.rdata", rdata, 32'd0);
        @(posedge clk); #1 rstN = 1'b1;
        repeat (3) @(posedge clk);
        #1 countOn = 1'b0;
        check("rstWait.noIssue", 32'(enCount), 32'd0);
        check("rstWait.err", 32'(errMisalign), 32'd0);

        // Error cases
        access("lw11", 1'b1, 1'b0, 3'd2, 32'h11, 32'h0, 1'b0, got);
        checkIdle("lw11");
        access("swOor", 1'b0, 1'b1, 3'd2, 32'(DEPTH*4), 32'hFFFFFFFF, 1'b0, got);
        access("lh1", 1'b1, 1'b0, 3'd1, 32'h1, 32'h0, 1'b0, got);
        access("ld011", 1'b1, 1'b0, 3'd3, 32'h0, 32'h0, 1'b0, got);
        access("st100", 1'b0, 1'b1, 3'd4, 32'h0, 32'h0, 1'b0, got);
        access("both", 1'b1, 1'b1, 3'd2, 32'h0, 32'h0, 1'b0, got);
        access("lw0", 1'b1, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0, got);
        check("lw0.noWrite", got, 32'h0);
        checkIdle("err");

        // Back-to-back loads
        access("seedW4", 1'b0, 1'b1, 3'd2, 32'h4, 32'h0BADF00D, 1'b0, got);
        checkIdle("seedW4");
        #1;
        enCount = 0; rdyCount = 0; countOn = 1'b1;
        access("b2b0", 1'b1, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0, got);
        access("b2b4", 1'b1, 1'b0, 3'd2, 32'h4, 32'h0, 1'b0, got);
        #1 countOn = 1'b0;
        check("b2b.enPulses", 32'(enCount), 32'd2);
        check("b2b.readyPulses", 32'(rdyCount), 32'd2);
        checkIdle("b2b");

        // Randomised traffic against the reference model
        for (int n = 0; n < 120; n++) begin
            r  = int'($urandom_range(0, 9));
            rd = (r <= 5);
            wr = (r == 0) || (r >= 6);
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (rd && !wr) begin
                r = int'($urandom_range(0, 4));
                f3 = (r == 3) ? 3'd4 : (r == 4) ? 3'd5 : 3'(r);
            end else f3 = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 11) == 0) a = 32'(DEPTH*4) + 32'($urandom_range(0, 15));
            else a = 32'($urandom_range(0, 63));
            access("rnd", rd, wr, f3, a, $urandom, rd && !wr && ($urandom_range(0, 1) == 1), got);
            if ($urandom_range(0, 1) == 1) checkIdle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
